// File: rtl/sonar_rx_parser_if.sv
// Byte-in / frame-out bundle between the UART receiver, the sonar frame parser
// and its consumers. The parser takes the slave side.
interface sonar_rx_parser_if #(
    parameter int N_DIG_ANG  = 3,
    parameter int N_DIG_DIST = 3
);
    logic [7:0]              dado_recebido;
    logic                    pronto_rx;
    logic [4*N_DIG_ANG-1:0]  angulo;
    logic [4*N_DIG_DIST-1:0] distancia;
    logic                    mensagem_valida;
    logic                    erro;
    logic [3:0]              db_estado;

    modport master (
        output dado_recebido, pronto_rx,
        input  angulo, distancia, mensagem_valida, erro, db_estado
    );

    modport slave (
        input  dado_recebido, pronto_rx,
        output angulo, distancia, mensagem_valida, erro, db_estado
    );
endinterface

// File: rtl/sonar_rx_parser.sv
// Decodes ASCII sonar reports "aaa,ddd#" into BCD angle/distance with valid/error pulses.
// Optional inter-byte timeout is built when SONAR_RX_TIMEOUT_EN is defined.
//
// state      | meaning
// INICIAL    | idle, skipping bytes until the first angle digit
// ANGULO     | collecting angle digits
// ESPERA_SEP | angle complete, expecting the separator
// DISTANCIA  | collecting distance digits
// ESPERA_FIM | distance complete, expecting the terminator
// VALIDA     | one-cycle frame-accepted pulse
// ERRO       | one-cycle frame-aborted pulse
module sonar_rx_parser #(
    parameter int         N_DIG_ANG      = 3,
    parameter int         N_DIG_DIST     = 3,
    parameter logic [7:0] SEPARADOR      = 8'h2C,
    parameter logic [7:0] TERMINADOR     = 8'h23,
    parameter int         TIMEOUT_CICLOS = 50000
) (
    input logic               clock,
    input logic               reset,
    sonar_rx_parser_if.slave  bus
);
    localparam int ANG_W   = 4 * N_DIG_ANG;
    localparam int DIST_W  = 4 * N_DIG_DIST;
    localparam int MAX_DIG = (N_DIG_ANG > N_DIG_DIST) ? N_DIG_ANG : N_DIG_DIST;
    localparam int CNT_W   = $clog2(MAX_DIG + 1);
    localparam logic [CNT_W-1:0] N_ANG_C  = CNT_W'(N_DIG_ANG);
    localparam logic [CNT_W-1:0] N_DIST_C = CNT_W'(N_DIG_DIST);

    if (N_DIG_ANG < 1 || N_DIG_DIST < 1 || TIMEOUT_CICLOS < 2) begin : g_cfg_check
        $error("sonar_rx_parser: invalid parameter set");
    end

    typedef enum logic [3:0] {
        INICIAL    = 4'b0000,
        ANGULO     = 4'b0001,
        ESPERA_SEP = 4'b0010,
        DISTANCIA  = 4'b0011,
        ESPERA_FIM = 4'b0100,
        VALIDA     = 4'b0101,
        ERRO       = 4'b1110
    } estado_t;

    estado_t             estado, estado_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx, cnt_inc;
    logic [ANG_W-1:0]    ang_sh, angulo_r;
    logic [DIST_W-1:0]   dist_sh, distancia_r;
    logic                eh_digito;
    logic [3:0]          nibble;
    logic                ang_first, ang_shift, dist_shift, commit;

    assign eh_digito = (bus.dado_recebido >= 8'h30) && (bus.dado_recebido <= 8'h39);
    assign nibble    = bus.dado_recebido[3:0];
    assign cnt_inc   = cnt + CNT_W'(1);

`ifdef SONAR_RX_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TMR_W-1:0] TMR_CARGA = TMR_W'(TIMEOUT_CICLOS - 1);

    logic [TMR_W-1:0] tmr;
    logic             aguardando;

    assign aguardando = (estado == ANGULO) || (estado == ESPERA_SEP) ||
                        (estado == DISTANCIA) || (estado == ESPERA_FIM);

    // Down-counter reloads on every byte and on every state change; zero means the line went quiet.
    always_ff @(posedge clock) begin
        if (reset || bus.pronto_rx || (estado_nx != estado)) begin
            tmr <= TMR_CARGA;
        end else if (aguardando && (tmr != '0)) begin
            tmr <= tmr - TMR_W'(1);
        end
    end
`endif

    always_comb begin
        estado_nx  = estado;
        cnt_nx     = cnt;
        ang_first  = 1'b0;
        ang_shift  = 1'b0;
        dist_shift = 1'b0;
        commit     = 1'b0;
        case (estado)
            INICIAL: begin
                if (bus.pronto_rx && eh_digito) begin
                    ang_first = 1'b1;
                    if (N_DIG_ANG == 1) begin
                        estado_nx = ESPERA_SEP;
                        cnt_nx    = '0;
                    end else begin
                        estado_nx = ANGULO;
                        cnt_nx    = CNT_W'(1);
                    end
                end
            end
            ANGULO: begin
                if (bus.pronto_rx) begin
                    if (eh_digito) begin
                        ang_shift = 1'b1;
                        if (cnt_inc == N_ANG_C) begin
                            estado_nx = ESPERA_SEP;
                            cnt_nx    = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        estado_nx = ERRO;
                    end
                end
            end
            ESPERA_SEP: begin
                if (bus.pronto_rx) begin
                    estado_nx = (bus.dado_recebido == SEPARADOR) ? DISTANCIA : ERRO;
                end
            end
            DISTANCIA: begin
                if (bus.pronto_rx) begin
                    if (eh_digito) begin
                        dist_shift = 1'b1;
                        if (cnt_inc == N_DIST_C) begin
                            estado_nx = ESPERA_FIM;
                            cnt_nx    = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        estado_nx = ERRO;
                    end
                end
            end
            ESPERA_FIM: begin
                if (bus.pronto_rx) begin
                    if (bus.dado_recebido == TERMINADOR) begin
                        estado_nx = VALIDA;
                        commit    = 1'b1;
                    end else begin
                        estado_nx = ERRO;
                    end
                end
            end
            VALIDA, ERRO: begin
                estado_nx = INICIAL;
                cnt_nx    = '0;
            end
            default: begin
                estado_nx = INICIAL;
                cnt_nx    = '0;
            end
        endcase
`ifdef SONAR_RX_TIMEOUT_EN
        if (aguardando && !bus.pronto_rx && (tmr == '0)) begin
            estado_nx = ERRO;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= INICIAL;
            cnt         <= '0;
            ang_sh      <= '0;
            dist_sh     <= '0;
            angulo_r    <= '0;
            distancia_r <= '0;
        end else begin
            estado <= estado_nx;
            cnt    <= cnt_nx;
            if (ang_first) begin
                ang_sh  <= ANG_W'(nibble);
                dist_sh <= '0;
            end else if (ang_shift) begin
                ang_sh <= ANG_W'({ang_sh, nibble});
            end else if (dist_shift) begin
                dist_sh <= DIST_W'({dist_sh, nibble});
            end
            if (commit) begin
                angulo_r    <= ang_sh;
                distancia_r <= dist_sh;
            end
        end
    end

    assign bus.angulo          = angulo_r;
    assign bus.distancia       = distancia_r;
    assign bus.mensagem_valida = (estado == VALIDA);
    assign bus.erro            = (estado == ERRO);

    always_comb begin
        case (estado)
            INICIAL, ANGULO, ESPERA_SEP, DISTANCIA, ESPERA_FIM, VALIDA, ERRO:
                bus.db_estado = estado;
            default:
                bus.db_estado = 4'b1111;
        endcase
    end
endmodule
